// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one serial-operand ALU between two requesters.
// Streams both operands, collects one or two result bytes, aborts on a watchdog timeout.
module alu_scheduler #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned W       = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_i,
  input  logic [1:0]     op0_i,
  input  logic [W-1:0]   a0_i,
  input  logic [W-1:0]   b0_i,
  input  logic [1:0]     op1_i,
  input  logic [W-1:0]   a1_i,
  input  logic [W-1:0]   b1_i,
  output logic [1:0]     gnt_o,
  output logic [1:0]     done_o,
  output logic [1:0]     err_o,
  output logic [2*W-1:0] result_o,
  output logic           busy_o,
  output logic [1:0]     alu_op_o,
  output logic           alu_valid_o,
  output logic [W-1:0]   alu_in_o,
  input  logic           alu_ready_i,
  input  logic [W-1:0]   alu_o_i
);

  localparam int unsigned WDW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             nb_q, nb_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic             busy_q, busy_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             alu_valid_q, alu_valid_d;
  logic [W-1:0]     alu_in_q, alu_in_d;
  logic [2*W-1:0]   result_q, result_d;

  logic             win;
  logic [1:0]       owner_oh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      b_q         <= '0;
      lo_q        <= '0;
      nb_q        <= 1'b0;
      wd_q        <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      alu_op_q    <= '0;
      alu_valid_q <= 1'b0;
      alu_in_q    <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      b_q         <= b_d;
      lo_q        <= lo_d;
      nb_q        <= nb_d;
      wd_q        <= wd_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      alu_op_q    <= alu_op_d;
      alu_valid_q <= alu_valid_d;
      alu_in_q    <= alu_in_d;
      result_q    <= result_d;
    end
  end

  // On a tie the port not served last wins; a lone requester always wins.
  assign win      = (&req_i) ? ~last_q : req_i[1];
  assign owner_oh = owner_q ? 2'b10 : 2'b01;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    b_d         = b_q;
    lo_d        = lo_q;
    nb_d        = nb_q;
    wd_d        = wd_q;
    gnt_d       = '0;
    done_d      = '0;
    err_d       = '0;
    busy_d      = busy_q;
    alu_op_d    = alu_op_q;
    alu_valid_d = 1'b0;
    alu_in_d    = alu_in_q;
    result_d    = result_q;

    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          owner_d     = win;
          gnt_d       = win ? 2'b10 : 2'b01;
          busy_d      = 1'b1;
          alu_op_d    = win ? op1_i : op0_i;
          alu_in_d    = win ? a1_i : a0_i;
          b_d         = win ? b1_i : b0_i;
          alu_valid_d = 1'b1;
          state_d     = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        alu_valid_d = 1'b1;
        alu_in_d    = b_q;
        state_d     = S_LOAD_B;
      end
      S_LOAD_B: begin
        wd_d    = '0;
        nb_d    = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // op bit 0 set means mul/div, which return a second (high) byte.
        if (alu_ready_i) begin
          wd_d = '0;
          if (!alu_op_q[0] || nb_q) begin
            result_d = alu_op_q[0] ? {alu_o_i, lo_q} : {{W{1'b0}}, alu_o_i};
            done_d   = owner_oh;
            busy_d   = 1'b0;
            state_d  = S_FIN;
          end else begin
            lo_d = alu_o_i;
            nb_d = 1'b1;
          end
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          err_d   = owner_oh;
          busy_d  = 1'b0;
          last_d  = owner_q;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      S_FIN: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign alu_op_o    = alu_op_q;
  assign alu_valid_o = alu_valid_q;
  assign alu_in_o    = alu_in_q;
  assign result_o    = result_q;

endmodule
